// File: rtl/up_dn_counter_driver.sv
// Command-side initiator for an up/down counter: turns LOAD / SEEK / STEP_UP /
// STEP_DN commands into single-cycle Load/Up/Down strobes and reports Done/Err.
module up_dn_counter_driver #(
  parameter int WIDTH = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [1:0]       Cmd_Op,
  input  logic [WIDTH-1:0] Cmd_Data,
  output logic             Done,
  output logic             Err,
  output logic [WIDTH-1:0] IN,
  output logic             Load,
  output logic             Up,
  output logic             Down,
  input  logic [WIDTH-1:0] Counter,
  input  logic             High,
  input  logic             Low
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SEEK = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DN   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_EVAL,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] in_q, in_d;
  logic             load_q, load_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             idle;
  logic [1:0]       ev_op;
  logic [WIDTH-1:0] ev_tgt;
  logic [WIDTH-1:0] ev_rem;
  logic             st_up, st_dn, st_fin, st_err;
  logic             apply_step;

  assign idle      = (state_q == S_IDLE);
  assign Cmd_Ready = idle && !Rst;

  // Step decision: taken at the accept edge from the live command inputs, and
  // at the end of every SETTLE cycle from the latched command.
  always_comb begin
    ev_op  = idle ? Cmd_Op   : op_q;
    ev_tgt = idle ? Cmd_Data : data_q;
    ev_rem = idle ? Cmd_Data : rem_q;
    st_up  = 1'b0;
    st_dn  = 1'b0;
    st_fin = 1'b0;
    st_err = 1'b0;
    case (ev_op)
      OP_SEEK: begin
        if (Counter < ev_tgt)      st_up  = 1'b1;
        else if (Counter > ev_tgt) st_dn  = 1'b1;
        else                       st_fin = 1'b1;
      end
      OP_UP: begin
        if (ev_rem == '0) st_fin = 1'b1;
        else if (High) begin
          st_fin = 1'b1;
          st_err = 1'b1;
        end else st_up = 1'b1;
      end
      OP_DN: begin
        if (ev_rem == '0) st_fin = 1'b1;
        else if (Low) begin
          st_fin = 1'b1;
          st_err = 1'b1;
        end else st_dn = 1'b1;
      end
      default: st_fin = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    rem_d      = rem_q;
    in_d       = in_q;
    load_d     = 1'b0;
    up_d       = 1'b0;
    dn_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    apply_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Cmd_Valid && Cmd_Ready) begin
          op_d   = Cmd_Op;
          data_d = Cmd_Data;
          if (Cmd_Op == OP_LOAD) begin
            load_d  = 1'b1;
            in_d    = Cmd_Data;
            state_d = S_LOAD;
          end else begin
            apply_step = 1'b1;
          end
        end
      end
      S_LOAD:   state_d = S_VERIFY;
      S_VERIFY: begin
        done_d  = 1'b1;
        err_d   = (Counter != data_q);
        state_d = S_DONE;
      end
      S_EVAL:   state_d = S_SETTLE;
      S_SETTLE: apply_step = 1'b1;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (apply_step) begin
      if (st_fin) begin
        done_d  = 1'b1;
        err_d   = st_err;
        state_d = S_DONE;
      end else begin
        up_d    = st_up;
        dn_d    = st_dn;
        rem_d   = ev_rem - WIDTH'(1);
        state_d = S_EVAL;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      rem_q   <= '0;
      in_q    <= '0;
      load_q  <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      in_q    <= in_d;
      load_q  <= load_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign IN   = in_q;
  assign Load = load_q;
  assign Up   = up_q;
  assign Down = dn_q;
  assign Done = done_q;
  assign Err  = err_q;

endmodule

// File: tb/tb_up_dn_counter_driver.sv
// Directed bench for up_dn_counter_driver driving a behavioural 5-bit up/down
// counter; strobe patterns and Done timing are captured per cycle and checked.
module tb_up_dn_counter_driver;

  localparam int W = 5;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Cmd_Valid = 1'b0;
  logic         Cmd_Ready;
  logic [1:0]   Cmd_Op = 2'b00;
  logic [W-1:0] Cmd_Data = '0;
  logic         Done, Err, Load, Up, Down;
  logic [W-1:0] IN;
  logic [W-1:0] Counter;
  logic         High, Low;
  logic         ignore_ld = 1'b0;

  int passed = 0;
  int total  = 0;

  logic [31:0] up_m, dn_m, ld_m;
  int          done_cyc;
  logic        err_at_done, rdy_after, done_after, rdy1, multi;
  logic [W-1:0] in1, cnt2;

  always #5 Clk = ~Clk;

  // Counter model: Load beats Down beats Up; ignore_ld emulates a stuck load.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) Counter <= 5'd5;
    else if (Load && !ignore_ld) Counter <= IN;
    else if (Down) Counter <= Counter - 5'd1;
    else if (Up) Counter <= Counter + 5'd1;
  end
  assign High = (Counter == 5'd31);
  assign Low  = (Counter == 5'd0);

  up_dn_counter_driver #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_Op(Cmd_Op), .Cmd_Data(Cmd_Data), .Done(Done), .Err(Err),
    .IN(IN), .Load(Load), .Up(Up), .Down(Down),
    .Counter(Counter), .High(High), .Low(Low)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at a falling edge while idle; returns at the falling edge of the
  // cycle after Done, which is a valid cycle 0 for the next command.
  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] d);
    up_m = '0; dn_m = '0; ld_m = '0;
    done_cyc = -1; err_at_done = 1'b0; rdy_after = 1'b0; done_after = 1'b1;
    multi = 1'b0; rdy1 = 1'b1; in1 = '0; cnt2 = '0;
    Cmd_Op = op; Cmd_Data = d; Cmd_Valid = 1'b1;
    @(negedge Clk);
    Cmd_Valid = 1'b0; Cmd_Op = ~op; Cmd_Data = ~d;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge Clk);
      up_m[c] = Up; dn_m[c] = Down; ld_m[c] = Load;
      if ((32'(Up) + 32'(Down) + 32'(Load)) > 1) multi = 1'b1;
      if (c == 1) begin rdy1 = Cmd_Ready; in1 = IN; end
      if (c == 2) cnt2 = Counter;
      if (done_cyc >= 0) begin
        rdy_after = Cmd_Ready; done_after = Done;
        break;
      end
      if (Done) begin done_cyc = c; err_at_done = Err; end
    end
  endtask

  task automatic chk_cmd(input string tag, input logic [31:0] e_up, input logic [31:0] e_dn,
                         input logic [31:0] e_ld, input int e_done, input logic e_err);
    chk({tag, "_up"}, up_m, e_up);
    chk({tag, "_dn"}, dn_m, e_dn);
    chk({tag, "_ld"}, ld_m, e_ld);
    chk({tag, "_done_cyc"}, done_cyc, e_done);
    chk({tag, "_err"}, 32'(err_at_done), 32'(e_err));
    chk({tag, "_rdy_ctl"}, {30'd0, rdy1, rdy_after}, 32'b01);
    chk({tag, "_done_pulse"}, {30'd0, done_after, multi}, 32'b00);
  endtask

  initial begin
    #2;
    chk("rst_outs", {27'd0, Load, Up, Down, Done, Err}, 32'd0);
    chk("rst_in_rdy", {26'd0, IN, Cmd_Ready}, 32'd0);
    @(negedge Clk); @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rdy_after_rst", 32'(Cmd_Ready), 32'd1);
    chk("cnt_init", 32'(Counter), 32'd5);

    run_cmd(2'b00, 5'd9);
    chk_cmd("load9", 32'h0, 32'h0, 32'h2, 3, 1'b0);
    chk("load9_in1", 32'(in1), 32'd9);
    chk("load9_cnt2", 32'(cnt2), 32'd9);

    run_cmd(2'b10, 5'd3);
    chk_cmd("up3", 32'h2A, 32'h0, 32'h0, 7, 1'b0);
    chk("up3_cnt", 32'(Counter), 32'd12);
    chk("up3_in_hold", 32'(IN), 32'd9);

    run_cmd(2'b00, 5'd29);
    chk_cmd("load29", 32'h0, 32'h0, 32'h2, 3, 1'b0);
    run_cmd(2'b10, 5'd5);
    chk_cmd("up5_sat", 32'hA, 32'h0, 32'h0, 5, 1'b1);
    chk("up5_cnt_high", {26'd0, Counter, High}, {26'd0, 5'd31, 1'b1});

    run_cmd(2'b00, 5'd2);
    run_cmd(2'b11, 5'd4);
    chk_cmd("dn4_sat", 32'h0, 32'hA, 32'h0, 5, 1'b1);
    chk("dn4_cnt_low", {26'd0, Counter, Low}, {26'd0, 5'd0, 1'b1});

    run_cmd(2'b00, 5'd17);
    run_cmd(2'b01, 5'd20);
    chk_cmd("seek17_20", 32'h2A, 32'h0, 32'h0, 7, 1'b0);
    chk("seek17_20_cnt", 32'(Counter), 32'd20);
    run_cmd(2'b01, 5'd20);
    chk_cmd("seek_eq", 32'h0, 32'h0, 32'h0, 1, 1'b0);

    run_cmd(2'b00, 5'd3);
    run_cmd(2'b01, 5'd0);
    chk_cmd("seek3_0", 32'h0, 32'h2A, 32'h0, 7, 1'b0);
    chk("seek3_0_cnt", 32'(Counter), 32'd0);

    run_cmd(2'b10, 5'd0);
    chk_cmd("up0", 32'h0, 32'h0, 32'h0, 1, 1'b0);

    ignore_ld = 1'b1;
    run_cmd(2'b00, 5'd6);
    ignore_ld = 1'b0;
    chk_cmd("load_bad", 32'h0, 32'h0, 32'h2, 3, 1'b1);
    chk("load_bad_in", 32'(IN), 32'd6);

    // Reset in cycle 3 of STEP_UP 4.
    Cmd_Op = 2'b10; Cmd_Data = 5'd4; Cmd_Valid = 1'b1;
    @(negedge Clk); Cmd_Valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("abort_up_c3", 32'(Up), 32'd1);
    Rst = 1'b1;
    #1;
    chk("abort_outs", {26'd0, Load, Up, Down, Done, Err, Cmd_Ready}, 32'd0);
    chk("abort_in", 32'(IN), 32'd0);
    @(negedge Clk); @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    chk("abort_rdy", 32'(Cmd_Ready), 32'd1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge Clk);
        if (Done || Up || Down || Load) seen = 1'b1;
      end
      chk("abort_quiet", 32'(seen), 32'd0);
    end

    run_cmd(2'b00, 5'd7);
    chk_cmd("load7_post", 32'h0, 32'h0, 32'h2, 3, 1'b0);
    chk("load7_cnt", 32'(Counter), 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
